loa_pipe_adder: RTL and testbench
=================================

Name: loa_pipe_adder

Overview:
- Parametrised, pipelined lower-part-OR approximate adder. The approximation depth is selectable per operation at run time, from 0 (exact) to KMAX.
- Operands enter and results leave through valid/ready handshakes with full backpressure.
- An integrated error monitor compares each result against the exact sum and keeps mismatch count and worst-case error.
- Sits in the adders library as the drop-in streaming successor to the fixed-K combinational LOA adder, for accelerator datapaths and accuracy characterisation.

Parameters:
- N, 8, operand and sum width (N >= 2).
- KMAX, 4, largest selectable approximate lower-part width (0 <= KMAX <= N).
- STAGES, 2, pipeline depth (1 or 2); equals latency in cycles with no backpressure.
- CW, 16, width of the error-count register.

Ports:
- i_Clk  in  1  clock, rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Valid  in  1  operand valid.
- o_Ready  out  1  adder can accept an operand this cycle.
- i_A  in  N  operand A.
- i_B  in  N  operand B.
- i_K  in  clog2(KMAX+1)  approximate lower-part width for this operand pair.
- o_Valid  out  1  result valid.
- i_Ready  in  1  downstream accepts the result.
- o_Sum  out  N  approximate sum.
- o_Cout  out  1  carry out of the accurate upper part.
- o_Err  out  1  this result differs from the exact sum.
- i_ClrStats  in  1  synchronous clear of the statistics.
- o_ErrCnt  out  CW  count of mismatching results, saturating.
- o_ErrMax  out  N+1  maximum absolute error observed.

Behaviour:
- Arithmetic, for effective k = min(i_K, KMAX):
  - Sum[k-1:0] = A|B.
  - Carry into bit k = A[k-1]&B[k-1] if k>0, else 0.
  - Sum[N-1:k] and Cout are the exact add of the upper bits plus that carry.
  - k=0 gives the exact N-bit add.
- Exact reference = A+B, N+1 bits.
- err = |{Cout,Sum} - exact|. o_Err = (err != 0).
- i_K is captured with its operands. A K change never affects operations already in flight.
- Transfer rule: a transfer occurs on an edge where valid & ready are both high (input and output sides independently).
- Pipeline advances when adv = !o_Valid | i_Ready. o_Ready = adv, combinational from i_Ready and the pipeline state; no valid-to-ready path.
- Per-stage behaviour:
  - Each stage holds a valid bit plus its payload.
  - On adv, every stage loads from the previous one; stage 0 loads {i_Valid, operands, k}.
  - When adv=0, all stages hold.
  - Bubbles do not collapse; a simple stall-all pipeline is acceptable.
- STAGES=2 split:
  - Stage 1 registers the lower OR result, the lower carry and the upper operands.
  - Stage 2 registers the upper sum, Cout, o_Err and err.
- STAGES=1: everything is computed at the input and registered once.
- o_Sum, o_Cout and o_Err hold their value while o_Valid=1 and i_Ready=0. They are don't-care when o_Valid=0 but must not be X after reset.
- Statistics update on each output transfer:
  - if o_Err, o_ErrCnt += 1, saturating at 2^CW-1;
  - o_ErrMax = max(o_ErrMax, err).
- i_ClrStats zeroes both statistics registers. If a clear and an update fall on the same edge, the clear wins and the update is discarded.
- Reset: all valid bits, o_Sum, o_Cout, o_Err, o_ErrCnt and o_ErrMax go to 0 immediately. After reset, o_Ready = 1.
- Reset mid-operation discards all in-flight results; nothing is emitted for them.
- Latency: STAGES cycles from input transfer to o_Valid, absent stalls. Throughput is one result per cycle.
- i_K > KMAX is clamped to KMAX; this is not an error.

Test Plan (N=8, KMAX=4, STAGES=2 unless stated):
- Exact mode: A=0x0F, B=0x01, K=0 -> after 2 cycles Sum=0x10, Cout=0, Err=0; stats unchanged.
- Approximation: A=0x0F, B=0x01, K=4 -> Sum=0x0F, Err=1, ErrCnt=1, ErrMax=1. Then A=0x08, B=0x08, K=4 -> Sum=0x18, ErrCnt=2, ErrMax=8.
- Upper carry: A=0xF0, B=0x20, K=4 -> Sum=0x10, Cout=1, Err=0. K=7 -> clamped to 4, same result.
- Backpressure: stream 6 operands with i_Ready low for cycles 3-5 -> no loss or duplication, order preserved, o_Sum stable while stalled, o_Ready low during the stall.
- Reset with 2 operations in flight -> o_Valid=0 immediately; no stale output after release. Separately, i_ClrStats coinciding with an erroring transfer -> ErrCnt=0, ErrMax=0.
- Saturation with CW=2: feed 5 erroring results -> ErrCnt stops at 3. Repeat with STAGES=1 -> latency is 1 cycle.

Source files
------------

// File: rtl/loa_pipe_adder.sv
// Pipelined lower-part-OR approximate adder with a run-time selectable
// approximation depth and an error monitor over the emitted results.
module loa_pipe_adder #(
  parameter int N      = 8,
  parameter int KMAX   = 4,
  parameter int STAGES = 2,
  parameter int CW     = 16,
  localparam int KW    = (KMAX > 0) ? $clog2(KMAX + 1) : 1
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Valid,
  output logic          o_Ready,
  input  logic [N-1:0]  i_A,
  input  logic [N-1:0]  i_B,
  input  logic [KW-1:0] i_K,
  output logic          o_Valid,
  input  logic          i_Ready,
  output logic [N-1:0]  o_Sum,
  output logic          o_Cout,
  output logic          o_Err,
  input  logic          i_ClrStats,
  output logic [CW-1:0] o_ErrCnt,
  output logic [N:0]    o_ErrMax
);

  localparam logic [KW-1:0] KMAX_K = KW'(KMAX);

  logic          adv;
  logic [KW-1:0] k_eff;
  logic [N:0]    a_ext, b_ext, low_mask, top_bit;
  logic [N:0]    in_lower, in_carry, in_upper_a, in_upper_b, in_exact;

  logic          b_valid;
  logic [N:0]    b_lower, b_carry, b_upper_a, b_upper_b, b_exact;
  logic [N:0]    approx, err_val, err_q;

  assign adv     = !o_Valid || i_Ready;
  assign o_Ready = adv;

  // Front half: split operands at bit k. The carry is kept pre-shifted to
  // bit k so the upper add needs no further knowledge of k.
  always_comb begin
    k_eff      = (i_K > KMAX_K) ? KMAX_K : i_K;
    a_ext      = {1'b0, i_A};
    b_ext      = {1'b0, i_B};
    low_mask   = ((N + 1)'(1) << k_eff) - (N + 1)'(1);
    top_bit    = low_mask ^ (low_mask >> 1);
    in_lower   = (a_ext | b_ext) & low_mask;
    in_carry   = ((a_ext & b_ext & top_bit) != '0) ? ((N + 1)'(1) << k_eff) : '0;
    in_upper_a = a_ext & ~low_mask;
    in_upper_b = b_ext & ~low_mask;
    in_exact   = a_ext + b_ext;
  end

  generate
    if (STAGES >= 2) begin : g_two_stage
      logic       s1_valid;
      logic [N:0] s1_lower, s1_carry, s1_upper_a, s1_upper_b, s1_exact;

      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          s1_valid   <= 1'b0;
          s1_lower   <= '0;
          s1_carry   <= '0;
          s1_upper_a <= '0;
          s1_upper_b <= '0;
          s1_exact   <= '0;
        end else if (adv) begin
          s1_valid   <= i_Valid;
          s1_lower   <= in_lower;
          s1_carry   <= in_carry;
          s1_upper_a <= in_upper_a;
          s1_upper_b <= in_upper_b;
          s1_exact   <= in_exact;
        end
      end

      assign b_valid   = s1_valid;
      assign b_lower   = s1_lower;
      assign b_carry   = s1_carry;
      assign b_upper_a = s1_upper_a;
      assign b_upper_b = s1_upper_b;
      assign b_exact   = s1_exact;
    end else begin : g_one_stage
      assign b_valid   = i_Valid;
      assign b_lower   = in_lower;
      assign b_carry   = in_carry;
      assign b_upper_a = in_upper_a;
      assign b_upper_b = in_upper_b;
      assign b_exact   = in_exact;
    end
  endgenerate

  // Upper sum bits below k are zero, so the OR merges the two halves.
  always_comb begin
    approx  = (b_upper_a + b_upper_b + b_carry) | b_lower;
    err_val = (approx >= b_exact) ? (approx - b_exact) : (b_exact - approx);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Valid <= 1'b0;
      o_Sum   <= '0;
      o_Cout  <= 1'b0;
      o_Err   <= 1'b0;
      err_q   <= '0;
    end else if (adv) begin
      o_Valid <= b_valid;
      o_Sum   <= approx[N-1:0];
      o_Cout  <= approx[N];
      o_Err   <= (err_val != '0);
      err_q   <= err_val;
    end
  end

  // A clear on the same edge as an output transfer discards that update.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_ErrCnt <= '0;
      o_ErrMax <= '0;
    end else if (i_ClrStats) begin
      o_ErrCnt <= '0;
      o_ErrMax <= '0;
    end else if (o_Valid && i_Ready) begin
      if (o_Err && (o_ErrCnt != '1)) begin
        o_ErrCnt <= o_ErrCnt + 1'b1;
      end
      if (err_q > o_ErrMax) begin
        o_ErrMax <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_loa_pipe_adder.sv
// Scoreboard bench: a two-stage/CW=16 instance under backpressure and a
// one-stage/CW=2 instance that always drains, both fed the same operands.
module tb_loa_pipe_adder;

  typedef struct packed {
    logic [7:0]  sum;
    logic        cout;
    logic        err;
    logic [8:0]  errv;
    logic [31:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       clr = 1'b0;
  logic       ready0 = 1'b1;
  logic       ready1 = 1'b1;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [2:0] in_k = '0;

  logic        o_ready0, o_valid0, o_cout0, o_err0;
  logic [7:0]  o_sum0;
  logic [15:0] cnt0;
  logic [8:0]  max0;
  logic        o_ready1, o_valid1, o_cout1, o_err1;
  logic [7:0]  o_sum1;
  logic [1:0]  cnt1;
  logic [8:0]  max1;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   bp_start = 0;
  bit   clr_rand = 1'b0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   m_cnt0 = 0, m_max0 = 0, m_cnt1 = 0, m_max1 = 0;
  bit   stall0 = 1'b0;
  logic [7:0] hold_sum0;
  logic hold_cout0, hold_err0;

  loa_pipe_adder #(.N(8), .KMAX(4), .STAGES(2), .CW(16)) dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(in_valid), .o_Ready(o_ready0),
    .i_A(in_a), .i_B(in_b), .i_K(in_k), .o_Valid(o_valid0), .i_Ready(ready0),
    .o_Sum(o_sum0), .o_Cout(o_cout0), .o_Err(o_err0), .i_ClrStats(clr),
    .o_ErrCnt(cnt0), .o_ErrMax(max0)
  );

  loa_pipe_adder #(.N(8), .KMAX(4), .STAGES(1), .CW(2)) dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(in_valid), .o_Ready(o_ready1),
    .i_A(in_a), .i_B(in_b), .i_K(in_k), .o_Valid(o_valid1), .i_Ready(ready1),
    .o_Sum(o_sum1), .o_Cout(o_cout1), .o_Err(o_err1), .i_ClrStats(clr),
    .o_ErrCnt(cnt1), .o_ErrMax(max1)
  );

  always #5 clk = ~clk;

  // Reference: split the operands arithmetically at bit k.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] k, input int c);
    exp_t m;
    int ai, bi, ke, lower, carry, upper, approx, exact, e;
    ai     = int'(a);
    bi     = int'(b);
    ke     = (int'(k) > 4) ? 4 : int'(k);
    lower  = (ai | bi) % (1 << ke);
    carry  = (ke > 0) ? (((ai >> (ke - 1)) & (bi >> (ke - 1))) & 1) : 0;
    upper  = (ai >> ke) + (bi >> ke) + carry;
    approx = upper * (1 << ke) + lower;
    exact  = ai + bi;
    e      = (approx > exact) ? approx - exact : exact - approx;
    m.sum  = 8'(approx);
    m.cout = ((approx >> 8) & 1) != 0;
    m.err  = (e != 0);
    m.errv = 9'(e);
    m.cyc  = 32'(c);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] k);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_k = k;
    clr = clr_rand && ($urandom_range(31) == 0);
    #1;
    while (!o_ready0 && guard < 200) begin
      @(negedge clk);
      clr = clr_rand && ($urandom_range(31) == 0);
      #1;
      guard++;
    end
    if (guard >= 200) checkOutput("accept_timeout", 32'(o_ready0), 32'd1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      clr = clr_rand && ($urandom_range(31) == 0);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    case (ready_mode)
      1:       ready0 = ($urandom_range(3) != 0);
      2:       ready0 = !((cyc - bp_start) >= 3 && (cyc - bp_start) <= 5);
      default: ready0 = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    #1;
    if (!rst && in_valid) begin
      if (o_ready0) q0.push_back(model(in_a, in_b, in_k, cyc));
      if (o_ready1) q1.push_back(model(in_a, in_b, in_k, cyc));
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      checkOutput("errcnt0", 32'(cnt0), 32'(m_cnt0));
      checkOutput("errmax0", 32'(max0), 32'(m_max0));
      checkOutput("ready_rule0", 32'(o_ready0), 32'(!o_valid0 || ready0));
      if (stall0) begin
        checkOutput("stall_valid0", 32'(o_valid0), 32'd1);
        checkOutput("stall_sum0", 32'(o_sum0), 32'(hold_sum0));
        checkOutput("stall_cout0", 32'(o_cout0), 32'(hold_cout0));
        checkOutput("stall_err0", 32'(o_err0), 32'(hold_err0));
      end
      if (o_valid0 && ready0) begin
        if (q0.size() == 0) begin
          checkOutput("spurious0", 32'(o_valid0), 32'd0);
        end else begin
          e0 = q0.pop_front();
          checkOutput("sum0", 32'(o_sum0), 32'(e0.sum));
          checkOutput("cout0", 32'(o_cout0), 32'(e0.cout));
          checkOutput("err0", 32'(o_err0), 32'(e0.err));
          checkOutput("latency0_min2", 32'((cyc - int'(e0.cyc)) >= 2), 32'd1);
          if (e0.err && m_cnt0 < 65535) m_cnt0++;
          if (int'(e0.errv) > m_max0) m_max0 = int'(e0.errv);
        end
      end
      if (clr) begin
        m_cnt0 = 0;
        m_max0 = 0;
      end
      stall0     = o_valid0 && !ready0;
      hold_sum0  = o_sum0;
      hold_cout0 = o_cout0;
      hold_err0  = o_err0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      checkOutput("errcnt1", 32'(cnt1), 32'(m_cnt1));
      checkOutput("errmax1", 32'(max1), 32'(m_max1));
      if (o_valid1) begin
        if (q1.size() == 0) begin
          checkOutput("spurious1", 32'(o_valid1), 32'd0);
        end else begin
          e1 = q1.pop_front();
          checkOutput("sum1", 32'(o_sum1), 32'(e1.sum));
          checkOutput("cout1", 32'(o_cout1), 32'(e1.cout));
          checkOutput("err1", 32'(o_err1), 32'(e1.err));
          checkOutput("latency1", 32'(cyc - int'(e1.cyc)), 32'd1);
          if (e1.err && m_cnt1 < 3) m_cnt1++;
          if (int'(e1.errv) > m_max1) m_max1 = int'(e1.errv);
        end
      end
      if (clr) begin
        m_cnt1 = 0;
        m_max1 = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_ready0", 32'(o_ready0), 32'd1);
    checkOutput("reset_valid0", 32'(o_valid0), 32'd0);
    checkOutput("reset_sum0", 32'(o_sum0), 32'd0);
    checkOutput("reset_cnt0", 32'(cnt0), 32'd0);
    checkOutput("reset_ready1", 32'(o_ready1), 32'd1);

    // Exact, approximate, upper carry and clamped-K cases.
    applyStimulus(8'h0F, 8'h01, 3'd0);
    applyStimulus(8'h0F, 8'h01, 3'd4);
    applyStimulus(8'h08, 8'h08, 3'd4);
    applyStimulus(8'hF0, 8'h20, 3'd4);
    applyStimulus(8'hF0, 8'h20, 3'd7);
    idleCycles(5);
    checkOutput("errcnt_after_approx", 32'(cnt0), 32'd2);
    checkOutput("errmax_after_approx", 32'(max0), 32'd8);

    // Six operands with the output stalled for three cycles.
    bp_start = cyc;
    ready_mode = 2;
    for (int i = 0; i < 6; i++) applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(7)));
    idleCycles(8);
    ready_mode = 0;

    for (int i = 0; i < 5; i++) applyStimulus(8'h0F, 8'h01, 3'd4);
    idleCycles(4);
    checkOutput("errcnt1_saturated", 32'(cnt1), 32'd3);

    // Clear on the same edge as an erroring output transfer.
    applyStimulus(8'h0F, 8'h01, 3'd4);
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!o_valid0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("clr_setup_valid0", 32'(o_valid0), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr_cnt0", 32'(cnt0), 32'd0);
    checkOutput("clr_max0", 32'(max0), 32'd0);
    idleCycles(3);

    // Reset with operations in flight.
    applyStimulus(8'h0F, 8'h01, 3'd4);
    applyStimulus(8'h08, 8'h08, 3'd4);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midreset_valid0", 32'(o_valid0), 32'd0);
    checkOutput("midreset_valid1", 32'(o_valid1), 32'd0);
    checkOutput("midreset_sum0", 32'(o_sum0), 32'd0);
    q0.delete();
    q1.delete();
    m_cnt0 = 0; m_max0 = 0; m_cnt1 = 0; m_max1 = 0;
    stall0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idleCycles(4);
    checkOutput("post_reset_valid0", 32'(o_valid0), 32'd0);

    // Randomised traffic with random backpressure and occasional clears.
    ready_mode = 1;
    clr_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) idleCycles(1);
      else applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(7)));
    end

    clr_rand = 1'b0;
    ready_mode = 0;
    guard = 0;
    while ((q0.size() != 0 || q1.size() != 0) && guard < 100) begin
      idleCycles(1);
      guard++;
    end
    idleCycles(2);
    checkOutput("drain0", 32'(q0.size()), 32'd0);
    checkOutput("drain1", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
